// File: rtl/lbp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lbp_pkg
//  Purpose  : Shared frame geometry, histogram size and FSM state encoding
//             for the LBP histogram block.
//  Revision : 1.0  initial release
// ============================================================================
package lbp_pkg;

    // Frame geometry: 128x128 pixels, address is {row[6:0], col[6:0]}
    localparam int IMG_W  = 128;
    localparam int IMG_H  = 128;
    localparam int ADDR_W = 14;

    // One bin per 8-bit LBP code
    localparam int NBINS  = 256;
    localparam int BIN_W  = 8;

    // Pixel total saturates at one full frame
    localparam int PIX_W   = 15;
    localparam int PIX_MAX = IMG_W * IMG_H;

    // Histogram controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // True when the address lies on the outermost row or column
    function automatic logic is_border(input logic [ADDR_W-1:0] addr);
        logic [6:0] row;
        logic [6:0] col;
        row = addr[13:7];
        col = addr[6:0];
        return (row == 7'd0) || (row == 7'(IMG_H - 1)) ||
               (col == 7'd0) || (col == 7'(IMG_W - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/lbp_hist_bank.sv
`default_nettype none
// ============================================================================
//  Module   : lbp_hist_bank
//  Purpose  : 256-entry register file of saturating bin counters with one
//             increment port and one read-and-clear port.
//  Revision : 1.0  initial release
// ============================================================================
module lbp_hist_bank
    import lbp_pkg::*;
#(
    parameter int CW = 15
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    // saturating increment port
    input  logic             inc_en_i,
    input  logic [BIN_W-1:0] inc_idx_i,
    // read-and-clear port
    input  logic [BIN_W-1:0] rd_idx_i,
    input  logic             clr_en_i,
    output logic [CW-1:0]    rd_data_o
);

    // Flat view of all bins for the read multiplexer
    logic [CW-1:0] w_bins [NBINS];

    // Each bin is its own register so that no storage element has more than
    // one driver; the increment and clear ports are never active together,
    // so clear simply takes priority.
    for (genvar g = 0; g < NBINS; g++) begin : g_bin
        logic [CW-1:0] bin_q;
        logic          w_inc_hit;
        logic          w_clr_hit;

        assign w_inc_hit = inc_en_i && (inc_idx_i == BIN_W'(g));
        assign w_clr_hit = clr_en_i && (rd_idx_i  == BIN_W'(g));

        // Per-bin counter: clear on read-out, else saturating increment
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                bin_q <= '0;
            end else if (w_clr_hit) begin
                bin_q <= '0;
            end else if (w_inc_hit && (bin_q != {CW{1'b1}})) begin
                bin_q <= bin_q + 1'b1;
            end
        end

        assign w_bins[g] = bin_q;
    end

    // Combinational read so a count written at edge N is visible right after N
    assign rd_data_o = w_bins[rd_idx_i];

endmodule
`default_nettype wire

// File: rtl/lbp_hist.sv
`default_nettype none
// ============================================================================
//  Module   : lbp_hist
//  Purpose  : Snoops the LBP write stream, accumulates a 256-bin histogram
//             of LBP codes for one 128x128 frame, then streams the bins out
//             over a valid/ready port, clearing each bin as it is accepted.
//  Revision : 1.0  initial release
// ============================================================================
module lbp_hist
    import lbp_pkg::*;
#(
    parameter int CW          = 15,
    parameter bit SKIP_BORDER = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    // LBP write stream
    input  logic              lbp_valid_i,
    input  logic [ADDR_W-1:0] lbp_addr_i,
    input  logic [BIN_W-1:0]  lbp_data_i,
    input  logic              finish_i,
    // histogram output stream
    output logic              hist_valid_o,
    input  logic              hist_ready_i,
    output logic [BIN_W-1:0]  hist_bin_o,
    output logic [CW-1:0]     hist_count_o,
    output logic              hist_last_o,
    output logic              hist_done_o,
    output logic [PIX_W-1:0]  pix_total_o
);

    state_t             state_q, state_d;
    logic               finish_q;
    logic [BIN_W-1:0]   drain_idx_q, drain_idx_d;
    logic [PIX_W-1:0]   pix_total_q, pix_total_d;

    logic               w_finish_rise;
    logic               w_collecting;
    logic               w_in_frame;
    logic               w_count;
    logic               w_draining;
    logic               w_accept;
    logic               w_last_bin;
    logic [CW-1:0]      w_rd_data;

    // A held-high finish must not retrigger a drain: only the 0->1 edge counts
    assign w_finish_rise = finish_i & ~finish_q;

    // Beats are only counted while collecting, and border pixels are dropped
    // when the border filter is enabled
    assign w_collecting  = (state_q == IDLE) || (state_q == ACCUM);
    assign w_in_frame    = !(SKIP_BORDER && is_border(lbp_addr_i));
    assign w_count       = lbp_valid_i && w_collecting && w_in_frame;

    assign w_draining    = (state_q == DRAIN);
    assign w_accept      = w_draining && hist_ready_i;
    assign w_last_bin    = (drain_idx_q == BIN_W'(NBINS - 1));

    // Finish edge detector
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            finish_q <= 1'b0;
        end else begin
            finish_q <= finish_i;
        end
    end

    // State, drain pointer and pixel total registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            drain_idx_q <= '0;
            pix_total_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_idx_q <= drain_idx_d;
            pix_total_q <= pix_total_d;
        end
    end

    // Next-state logic: a beat arriving with the finish edge is still
    // counted (the bank increment is independent of the transition)
    always_comb begin
        state_d     = state_q;
        drain_idx_d = drain_idx_q;
        pix_total_d = pix_total_q;

        case (state_q)
            IDLE: begin
                if (w_count) begin
                    pix_total_d = PIX_W'(1);
                    state_d     = ACCUM;
                end
                if (w_finish_rise) begin
                    state_d     = DRAIN;
                    drain_idx_d = '0;
                end
            end
            ACCUM: begin
                if (w_count && (pix_total_q != PIX_W'(PIX_MAX))) begin
                    pix_total_d = pix_total_q + 1'b1;
                end
                if (w_finish_rise) begin
                    state_d     = DRAIN;
                    drain_idx_d = '0;
                end
            end
            DRAIN: begin
                if (w_accept) begin
                    drain_idx_d = drain_idx_q + 1'b1;
                    if (w_last_bin) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    lbp_hist_bank #(
        .CW (CW)
    ) u_bank (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .inc_en_i  (w_count),
        .inc_idx_i (lbp_data_i),
        .rd_idx_i  (drain_idx_q),
        .clr_en_i  (w_accept),
        .rd_data_o (w_rd_data)
    );

    // Output beat is held steady during a stall because the drain pointer
    // only moves on acceptance and no increments happen while draining
    assign hist_valid_o = w_draining;
    assign hist_bin_o   = drain_idx_q;
    assign hist_count_o = w_draining ? w_rd_data : '0;
    assign hist_last_o  = w_draining && w_last_bin;
    assign hist_done_o  = (state_q == DONE);
    assign pix_total_o  = pix_total_q;

endmodule
`default_nettype wire

// File: tb/tb_lbp_hist.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lbp_hist
//  Purpose  : Self-checking bench for lbp_hist. Three instances share one
//             stimulus stream: full frame counting, border-skipping, and a
//             4-bit counter variant; each is compared with its own model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lbp_hist;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lbp_valid;
    logic [13:0] lbp_addr;
    logic [7:0]  lbp_data;
    logic        finish;
    logic        hist_ready;

    logic        hv [3];
    logic        hl [3];
    logic        hd [3];
    logic [7:0]  hb [3];
    logic [14:0] hc [3];
    logic [3:0]  hc2;
    logic [14:0] pt [3];

    int checks   = 0;
    int failures = 0;

    // Reference model: per instance bin counts, pixel total, frame-start flag
    int skp  [3] = '{0, 1, 0};
    int maxv [3] = '{32767, 32767, 15};
    int exp_bin [3][256];
    int exp_pix [3];
    bit new_frame [3];

    always #5 clk = ~clk;

    assign hc[2] = {11'd0, hc2};

    lbp_hist #(.CW(15), .SKIP_BORDER(1'b0)) u_full (
        .clk_i(clk), .rst_ni(rst_n), .lbp_valid_i(lbp_valid), .lbp_addr_i(lbp_addr),
        .lbp_data_i(lbp_data), .finish_i(finish), .hist_valid_o(hv[0]),
        .hist_ready_i(hist_ready), .hist_bin_o(hb[0]), .hist_count_o(hc[0]),
        .hist_last_o(hl[0]), .hist_done_o(hd[0]), .pix_total_o(pt[0]));

    lbp_hist #(.CW(15), .SKIP_BORDER(1'b1)) u_skip (
        .clk_i(clk), .rst_ni(rst_n), .lbp_valid_i(lbp_valid), .lbp_addr_i(lbp_addr),
        .lbp_data_i(lbp_data), .finish_i(finish), .hist_valid_o(hv[1]),
        .hist_ready_i(hist_ready), .hist_bin_o(hb[1]), .hist_count_o(hc[1]),
        .hist_last_o(hl[1]), .hist_done_o(hd[1]), .pix_total_o(pt[1]));

    lbp_hist #(.CW(4), .SKIP_BORDER(1'b0)) u_small (
        .clk_i(clk), .rst_ni(rst_n), .lbp_valid_i(lbp_valid), .lbp_addr_i(lbp_addr),
        .lbp_data_i(lbp_data), .finish_i(finish), .hist_valid_o(hv[2]),
        .hist_ready_i(hist_ready), .hist_bin_o(hb[2]), .hist_count_o(hc2),
        .hist_last_o(hl[2]), .hist_done_o(hd[2]), .pix_total_o(pt[2]));

    task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, idx, obs, exp);
        end
    endtask

    function automatic bit on_border(input logic [13:0] a);
        int row;
        int col;
        row = int'(a) / 128;
        col = int'(a) % 128;
        return (row == 0) || (row == 127) || (col == 0) || (col == 127);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            for (int b = 0; b < 256; b++) exp_bin[i][b] = 0;
            exp_pix[i]   = 0;
            new_frame[i] = 1'b1;
        end
    endfunction

    function automatic void model_count(input logic [13:0] a, input logic [7:0] c);
        for (int i = 0; i < 3; i++) begin
            if (!(skp[i] != 0 && on_border(a))) begin
                if (exp_bin[i][c] < maxv[i]) exp_bin[i][c] = exp_bin[i][c] + 1;
                if (new_frame[i]) exp_pix[i] = 1;
                else if (exp_pix[i] < 16384) exp_pix[i] = exp_pix[i] + 1;
                new_frame[i] = 1'b0;
            end
        end
    endfunction

    task automatic beat(input logic [13:0] a, input logic [7:0] c, input logic fin);
        @(negedge clk);
        lbp_valid = 1'b1;
        lbp_addr  = a;
        lbp_data  = c;
        finish    = fin;
        model_count(a, c);
    endtask

    task automatic raise_finish();
        @(negedge clk);
        lbp_valid = 1'b0;
        finish    = 1'b1;
    endtask

    function automatic logic [13:0] interior_addr();
        logic [6:0] r;
        logic [6:0] c;
        r = 7'($urandom_range(1, 126));
        c = 7'($urandom_range(1, 126));
        return {r, c};
    endfunction

    // Caller has just raised finish at the current negedge.
    // mode 0: ready always high, 1: ready pattern 1,0,0, 2: random ready
    task automatic run_drain(input int mode);
        int b   = 0;
        int cyc = 0;
        int k   = 0;
        bit rdy;
        chk("pre_drain_valid", 0, hv[0], 1'b0);
        @(negedge clk);
        lbp_valid = 1'b0;
        while (b < 256 && cyc < 4000) begin
            for (int i = 0; i < 3; i++) begin
                chk("drain_valid", i, hv[i], 1'b1);
                chk("drain_bin",   i, hb[i], b);
                chk("drain_count", i, hc[i], exp_bin[i][b]);
                chk("drain_last",  i, hl[i], (b == 255));
                chk("drain_done_low", i, hd[i], 1'b0);
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (k % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            k++;
            hist_ready = rdy;
            if (rdy) begin
                for (int i = 0; i < 3; i++) exp_bin[i][b] = 0;
                b++;
            end
            @(negedge clk);
            cyc++;
        end
        hist_ready = 1'b0;
        if (b < 256) chk("drain_timeout", 0, b, 256);
        if (mode == 0) chk("drain_cycles", 0, cyc, 256);
        for (int i = 0; i < 3; i++) begin
            chk("done_pulse", i, hd[i], 1'b1);
            chk("done_valid", i, hv[i], 1'b0);
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk("done_once", i, hd[i], 1'b0);
        // finish still high: no new drain may start
        repeat (4) begin
            @(negedge clk);
            chk("no_restart", 0, hv[0], 1'b0);
        end
        finish = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("pix_hold", i, pt[i], exp_pix[i]);
            new_frame[i] = 1'b1;
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        lbp_valid  = 1'b0;
        lbp_addr   = '0;
        lbp_data   = '0;
        finish     = 1'b0;
        hist_ready = 1'b0;
        model_reset();

        // Reset state
        #12;
        for (int i = 0; i < 3; i++) begin
            chk("rst_valid", i, hv[i], 1'b0);
            chk("rst_bin",   i, hb[i], 0);
            chk("rst_count", i, hc[i], 0);
            chk("rst_last",  i, hl[i], 1'b0);
            chk("rst_done",  i, hd[i], 1'b0);
            chk("rst_pix",   i, pt[i], 0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Step 1: full frame of code 0, full-throughput drain
        for (int a = 0; a < 16384; a++) beat(14'(a), 8'h00, 1'b0);
        raise_finish();
        chk("t1_pix_full", 0, pt[0], 16384);
        chk("t1_pix_skip", 1, pt[1], 15876);
        for (int i = 0; i < 3; i++) chk("t1_pix", i, pt[i], exp_pix[i]);
        run_drain(0);

        // Step 2: full frame of code 0xFF, random ready during drain
        for (int a = 0; a < 16384; a++) beat(14'(a), 8'hFF, 1'b0);
        raise_finish();
        chk("t2_pix_skip", 1, pt[1], 15876);
        for (int i = 0; i < 3; i++) chk("t2_pix", i, pt[i], exp_pix[i]);
        run_drain(2);

        // Step 3: five beats of 0x5A then a sixth together with the finish edge
        for (int j = 0; j < 5; j++) beat({7'd10, 7'(10 + j)}, 8'h5A, 1'b0);
        beat({7'd10, 7'd20}, 8'h5A, 1'b1);
        run_drain(0);

        // Step 4: random frame, ready pattern 1,0,0 then an empty second drain
        for (int j = 0; j < 400; j++) begin
            if ($urandom_range(0, 9) < 7) begin
                beat(14'($urandom_range(0, 16383)), 8'($urandom_range(0, 255)), 1'b0);
            end else begin
                @(negedge clk);
                lbp_valid = 1'b0;
            end
        end
        raise_finish();
        for (int i = 0; i < 3; i++) chk("t4_pix", i, pt[i], exp_pix[i]);
        run_drain(1);
        raise_finish();
        run_drain(1);

        // Step 5: reset in the middle of a frame, then a short clean frame
        for (int a = 0; a < 8000; a++) beat(14'(a), 8'(a), 1'b0);
        @(negedge clk);
        lbp_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("mid_rst_pix",   i, pt[i], 0);
            chk("mid_rst_valid", i, hv[i], 1'b0);
            chk("mid_rst_done",  i, hd[i], 1'b0);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 100; j++) beat(interior_addr(), 8'd3, 1'b0);
        raise_finish();
        chk("t5_pix", 0, pt[0], 100);
        for (int i = 0; i < 3; i++) chk("t5_pix_model", i, pt[i], exp_pix[i]);
        run_drain(0);

        // Step 6: twenty beats of code 7 saturate the 4-bit variant
        for (int j = 0; j < 20; j++) beat(interior_addr(), 8'd7, 1'b0);
        raise_finish();
        run_drain(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
